branch_resolve_ctrl: RTL
========================

Name: branch_resolve_ctrl

Overview:
Sequences the shared branch/JALR comparator in the execute stage. Accepts one control-flow instruction at a time, drives the comparator inputs from registers, and samples the comparator result one cycle later. Computes the redirect target and holds a redirect request until fetch accepts it, then asserts a bounded pipeline flush. Sits between decode/execute issue and the fetch PC mux.

Parameters:
XLEN, 32, datapath width; cmp_out is XLEN bits.
FLUSH_CYCLES, 2, cycles flush stays high after the redirect handshake (0 is legal).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
ex_valid  input  1  issue request; qualified only for opcode 1100011 (branch) or 1100111 (JALR)
ex_ready  output  1  controller can accept an issue
ex_opcode  input  7  instruction opcode
ex_funct3  input  3  instruction funct3
ex_pc  input  XLEN  PC of the instruction
ex_imm  input  XLEN  sign-extended immediate
ex_rs1  input  XLEN  rs1 operand
ex_rs2  input  XLEN  rs2 operand
cmp_a  output  XLEN  comparator operand 1 (registered)
cmp_b  output  XLEN  comparator operand 2 (registered): rs2 for branch, imm for JALR
cmp_opcode  output  7  comparator opcode (registered)
cmp_funct  output  3  comparator funct (registered)
cmp_out  input  XLEN  comparator result, combinational from cmp_* outputs
redirect_valid  output  1  redirect request to fetch
redirect_ready  input  1  fetch accepts redirect
redirect_pc  output  XLEN  redirect target
flush  output  1  kill younger instructions in IF/ID

Behaviour:
- Reset (async, any state): state IDLE; ex_ready=1; redirect_valid=0; flush=0; redirect_pc=0; cmp_a, cmp_b, cmp_funct=0; cmp_opcode=0; flush counter=0.
- States: IDLE, EVAL, REDIRECT, FLUSH. ex_ready=1 only in IDLE.
- IDLE: accept when ex_valid && opcode is branch or JALR. Load cmp_* and latch pc, imm, opcode, funct3 -> EVAL. ex_valid with any other opcode is ignored; the controller stays in IDLE.
- EVAL: sample cmp_out. The result is taken as follows:
  - Branch: taken = cmp_out[0].
  - Branch with funct3 010 or 011: forced not-taken regardless of cmp_out, because the comparator holds a stale value for these encodings.
  - JALR: always taken.
- Target computation:
  - Branch target = pc + imm, modulo 2^XLEN (wrap, no overflow flag).
  - JALR target = cmp_out with bit 0 cleared.
- EVAL exit: if taken, set redirect_valid=1 and redirect_pc=target -> REDIRECT; otherwise -> IDLE. A not-taken branch occupies 2 cycles.
- REDIRECT: flush=1. redirect_valid and redirect_pc are held stable until redirect_ready is high on a clock edge. On the handshake edge, redirect_valid drops; go to FLUSH with counter=FLUSH_CYCLES, or go straight to IDLE if FLUSH_CYCLES=0.
- FLUSH: flush=1. The counter decrements each cycle; go to IDLE on the edge where the counter reaches 1.
- flush is high for exactly (REDIRECT cycles + FLUSH_CYCLES).
- If redirect_ready is already high in the first REDIRECT cycle, the handshake completes in one cycle.
- cmp_* registers hold their last value outside accept edges.

Optional Feature:
BRANCH_STATS_EN.
- Defined: adds outputs stat_branches[31:0], stat_taken[31:0], stat_jalr[31:0].
  - Counters increment at EVAL exit for branch, taken branch, and JALR respectively.
  - Counters wrap at 2^32 and reset to 0 on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then BEQ, rs1=rs2=5, pc=0x100, imm=0x20 -> redirect_valid at cycle 2 with redirect_pc=0x120. With redirect_ready=1, flush stays high 1+2 cycles and ex_ready returns after that.
- BNE, rs1=rs2=7 (comparator out=0) -> no redirect, flush never high, ex_ready back high 2 cycles after accept.
- BLT, rs1=0xFFFFFFFF, rs2=1; then BLTU with the same operands -> BLT redirects, BLTU does not. pc=0xFFFFFFF0, imm=0x20 -> redirect_pc=0x00000010 (wrap).
- JALR, rs1=0x1001, imm=0x4 -> cmp_b=0x4, redirect_pc=0x1004. Hold redirect_ready=0 for 5 cycles -> redirect_valid, redirect_pc and flush held stable; ex_valid pulses during this window are ignored.
- funct3=010 branch with a stale cmp_out=1 -> not-taken. Non-control opcode 0110011 with ex_valid -> ignored.
- Assert rst during REDIRECT -> all outputs at reset values immediately, state IDLE. With BRANCH_STATS_EN: 3 branches (2 taken) + 1 JALR -> counters read 3/2/1.

Source files
------------

// File: rtl/branch_resolve_ctrl_if.sv
// Issue, comparator, and redirect signals of branch_resolve_ctrl.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface branch_resolve_ctrl_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [XLEN-1:0] cmp_a;
  logic [XLEN-1:0] cmp_b;
  logic [6:0]      cmp_opcode;
  logic [2:0]      cmp_funct;
  logic [XLEN-1:0] cmp_out;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;

  modport slave (
    input  ex_valid, ex_opcode, ex_funct3, ex_pc, ex_imm, ex_rs1, ex_rs2,
    input  cmp_out, redirect_ready,
    output ex_ready, cmp_a, cmp_b, cmp_opcode, cmp_funct,
    output redirect_valid, redirect_pc, flush
  );

  modport master (
    output ex_valid, ex_opcode, ex_funct3, ex_pc, ex_imm, ex_rs1, ex_rs2,
    output cmp_out, redirect_ready,
    input  ex_ready, cmp_a, cmp_b, cmp_opcode, cmp_funct,
    input  redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch/JALR resolution sequencer for the shared execute-stage comparator.
// Define BRANCH_STATS_EN to add branch/taken/JALR event counters.
module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  branch_resolve_ctrl_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_taken,
  output logic [31:0] stat_jalr
`endif
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EVAL     = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;
  localparam logic [1:0] S_FLUSH    = 2'd3;

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] cmp_a_q, cmp_a_d;
  logic [XLEN-1:0] cmp_b_q, cmp_b_d;
  logic [6:0]      cmp_opcode_q, cmp_opcode_d;
  logic [2:0]      cmp_funct_q, cmp_funct_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            accept;
  logic            is_jalr;
  logic            stale_cmp;
  logic            taken;
  logic [XLEN-1:0] target;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_taken_q, stat_taken_d;
  logic [31:0] stat_jalr_q, stat_jalr_d;
`endif

  always_comb begin
    accept    = bus.ex_valid && (bus.ex_opcode == OP_BRANCH || bus.ex_opcode == OP_JALR);
    is_jalr   = (cmp_opcode_q == OP_JALR);
    // funct3 010/011 leave the comparator output stale, so never trust it
    stale_cmp = (cmp_funct_q[2:1] == 2'b01);
    taken     = is_jalr || (bus.cmp_out[0] && !stale_cmp);
    target    = is_jalr ? {bus.cmp_out[XLEN-1:1], 1'b0} : pc_q + imm_q;
  end

  always_comb begin
    state_d          = state_q;
    cmp_a_d          = cmp_a_q;
    cmp_b_d          = cmp_b_q;
    cmp_opcode_d     = cmp_opcode_q;
    cmp_funct_d      = cmp_funct_q;
    pc_d             = pc_q;
    imm_d            = imm_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    cnt_d            = cnt_q;
`ifdef BRANCH_STATS_EN
    stat_branches_d  = stat_branches_q;
    stat_taken_d     = stat_taken_q;
    stat_jalr_d      = stat_jalr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmp_a_d      = bus.ex_rs1;
          cmp_b_d      = (bus.ex_opcode == OP_JALR) ? bus.ex_imm : bus.ex_rs2;
          cmp_opcode_d = bus.ex_opcode;
          cmp_funct_d  = bus.ex_funct3;
          pc_d         = bus.ex_pc;
          imm_d        = bus.ex_imm;
          state_d      = S_EVAL;
        end
      end
      S_EVAL: begin
`ifdef BRANCH_STATS_EN
        if (is_jalr) begin
          stat_jalr_d = stat_jalr_q + 32'd1;
        end else begin
          stat_branches_d = stat_branches_q + 32'd1;
          if (taken) stat_taken_d = stat_taken_q + 32'd1;
        end
`endif
        if (taken) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target;
          state_d          = S_REDIRECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REDIRECT: begin
        if (bus.redirect_ready) begin
          redirect_valid_d = 1'b0;
          if (FLUSH_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cmp_a_q          <= '0;
      cmp_b_q          <= '0;
      cmp_opcode_q     <= '0;
      cmp_funct_q      <= '0;
      pc_q             <= '0;
      imm_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      cmp_a_q          <= cmp_a_d;
      cmp_b_q          <= cmp_b_d;
      cmp_opcode_q     <= cmp_opcode_d;
      cmp_funct_q      <= cmp_funct_d;
      pc_q             <= pc_d;
      imm_q            <= imm_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      cnt_q            <= cnt_d;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
      stat_jalr_q     <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_taken_q    <= stat_taken_d;
      stat_jalr_q     <= stat_jalr_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
  assign stat_jalr     = stat_jalr_q;
`endif

  assign bus.ex_ready       = (state_q == S_IDLE);
  assign bus.flush          = (state_q == S_REDIRECT) || (state_q == S_FLUSH);
  assign bus.cmp_a          = cmp_a_q;
  assign bus.cmp_b          = cmp_b_q;
  assign bus.cmp_opcode     = cmp_opcode_q;
  assign bus.cmp_funct      = cmp_funct_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule
